// File: rtl/fetch_execute_sequencer.sv
// VR16 control FSM: fetch, decode hold, execute, ALU wait, writeback, halt; owns the PC.
// Strobes (alu_start, rf_we, rf_clear) are registered and appear the cycle after the deciding state.
module fetch_execute_sequencer #(
  parameter int ADDR_WIDTH  = 12,
  parameter int DEC_CYCLES  = 2,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  run_en,
  output logic                  imem_req,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic                  imem_valid,
  input  logic [15:0]           imem_rdata,
  output logic [15:0]           instr_out,
  input  logic [3:0]            opcode_in,
  input  logic [ADDR_WIDTH-1:0] jump_addr_in,
  output logic                  alu_start,
  output logic [3:0]            alu_op,
  input  logic                  alu_done,
  input  logic                  div_by_zero,
  output logic                  rf_we,
  output logic                  rf_clear,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic                  halted,
  output logic                  fault,
  output logic [2:0]            state_dbg
);

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_WAIT_MEM  = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_WAIT_ALU  = 3'd4,
    S_WRITEBACK = 3'd5,
    S_HALT      = 3'd6
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [15:0]           instr_q, instr_d;
  logic [2:0]            dec_cnt_q, dec_cnt_d;
  logic [7:0]            tmo_cnt_q, tmo_cnt_d;
  logic                  imem_req_q, imem_req_d;
  logic                  alu_start_q, alu_start_d;
  logic [3:0]            alu_op_q, alu_op_d;
  logic                  rf_we_q, rf_we_d;
  logic                  rf_clear_q, rf_clear_d;
  logic                  fault_q, fault_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_FETCH;
      pc_q        <= '0;
      instr_q     <= '0;
      dec_cnt_q   <= '0;
      tmo_cnt_q   <= '0;
      imem_req_q  <= 1'b0;
      alu_start_q <= 1'b0;
      alu_op_q    <= '0;
      rf_we_q     <= 1'b0;
      rf_clear_q  <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      instr_q     <= instr_d;
      dec_cnt_q   <= dec_cnt_d;
      tmo_cnt_q   <= tmo_cnt_d;
      imem_req_q  <= imem_req_d;
      alu_start_q <= alu_start_d;
      alu_op_q    <= alu_op_d;
      rf_we_q     <= rf_we_d;
      rf_clear_q  <= rf_clear_d;
      fault_q     <= fault_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    instr_d     = instr_q;
    dec_cnt_d   = dec_cnt_q;
    tmo_cnt_d   = tmo_cnt_q;
    imem_req_d  = 1'b0;
    alu_start_d = 1'b0;
    alu_op_d    = alu_op_q;
    rf_we_d     = 1'b0;
    rf_clear_d  = 1'b0;
    fault_d     = fault_q;
    case (state_q)
      S_FETCH: begin
        if (run_en) begin
          state_d    = S_WAIT_MEM;
          imem_req_d = 1'b1;
          tmo_cnt_d  = '0;
        end
      end
      S_WAIT_MEM: begin
        if (imem_valid) begin
          instr_d   = imem_rdata;
          pc_d      = pc_q + 1'b1;
          dec_cnt_d = '0;
          state_d   = S_DECODE;
        end else if (tmo_cnt_q == 8'(MEM_TIMEOUT - 1)) begin
          fault_d = 1'b1;
          state_d = S_HALT;
        end else begin
          tmo_cnt_d  = tmo_cnt_q + 8'd1;
          imem_req_d = 1'b1;
        end
      end
      S_DECODE: begin
        if (dec_cnt_q == 3'(DEC_CYCLES - 1)) state_d = S_EXECUTE;
        else dec_cnt_d = dec_cnt_q + 3'd1;
      end
      S_EXECUTE: begin
        case (opcode_in)
          4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'hB, 4'hC, 4'hD, 4'hE: begin
            alu_start_d = 1'b1;
            alu_op_d    = opcode_in;
            state_d     = S_WRITEBACK;
          end
          4'h6, 4'h7: begin
            alu_start_d = 1'b1;
            alu_op_d    = opcode_in;
            state_d     = S_WAIT_ALU;
          end
          4'h8: state_d = S_WRITEBACK;
          4'hA: begin
            rf_clear_d = 1'b1;
            state_d    = S_FETCH;
          end
          // JUMP target replaces the increment already applied at fetch
          4'h9: begin
            pc_d    = jump_addr_in;
            state_d = S_FETCH;
          end
          default: state_d = S_HALT;
        endcase
      end
      S_WAIT_ALU: begin
        if (alu_done) begin
          if (div_by_zero) begin
            fault_d = 1'b1;
            state_d = S_HALT;
          end else begin
            state_d = S_WRITEBACK;
          end
        end
      end
      S_WRITEBACK: begin
        rf_we_d = 1'b1;
        state_d = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  always_comb begin
    imem_req  = imem_req_q;
    imem_addr = pc_q;
    instr_out = instr_q;
    alu_start = alu_start_q;
    alu_op    = alu_op_q;
    rf_we     = rf_we_q;
    rf_clear  = rf_clear_q;
    pc        = pc_q;
    halted    = (state_q == S_HALT);
    fault     = fault_q;
    state_dbg = state_q;
  end

endmodule
